lsu: RTL

Load/store unit directly downstream of the core datapath's memory port. Consumes the datapath's ALUResult (address), WriteData and the controller's MemRead/MemWrite/funct3, and runs a valid/ready request plus response handshake to data memory. Returns an aligned, sign- or zero-extended ReadData to the datapath's result mux. Drives Stall to freeze the PC and register-file write until the access completes.

---
 rtl/lsu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: load/store unit bridging the core memory port to a valid/ready data-memory bus.
// Holds the core with Stall until the access completes, then commits in DONE.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_fault, r_we;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        w_access, w_illegal, w_timeout, w_exit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_load;

    assign w_access  = MemRead | MemWrite;
    assign w_illegal = (MemRead & MemWrite) | (Funct3[1:0] == 2'b11) | (Funct3[2:1] == 2'b11)
                     | (MemWrite & Funct3[2]) | ((Funct3[1:0] == 2'b01) & Addr[0])
                     | ((Funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00));
    assign w_be      = Funct3[1:0] == 2'b00 ? 4'b0001 << Addr[1:0]
                     : Funct3[1:0] == 2'b01 ? 4'b0011 << {Addr[1], 1'b0} : 4'b1111;
    assign w_wdata   = Funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}}
                     : Funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
    assign w_shift   = mem_rsp_rdata >> {r_off, 3'b000};
    assign w_load    = r_f3 == 3'b000 ? {{24{w_shift[7]}}, w_shift[7:0]}
                     : r_f3 == 3'b100 ? {24'b0, w_shift[7:0]}
                     : r_f3 == 3'b001 ? {{16{w_shift[15]}}, w_shift[15:0]}
                     : r_f3 == 3'b101 ? {16'b0, w_shift[15:0]} : w_shift;
    assign w_timeout = r_cnt >= LAST;
    assign w_exit    = r_state == REQ ? mem_req_ready : mem_rsp_valid;

    assign ReadData      = r_rdata;
    assign mem_req_addr  = r_addr;
    assign mem_req_we    = r_we;
    assign mem_req_wdata = r_wdata;
    assign mem_req_be    = r_be;

    always_comb begin
        w_next        = r_state;
        Stall         = 1'b0;
        mem_req_valid = 1'b0;
        Fault         = 1'b0;
        case (r_state)
            IDLE: begin
                Stall = w_access;
                if (w_access) w_next = w_illegal ? DONE : REQ;
            end
            REQ: begin
                Stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = RSP;
                else if (w_timeout) w_next = DONE;
            end
            RSP: begin
                Stall = 1'b1;
                if (mem_rsp_valid | w_timeout) w_next = DONE;
            end
            default: begin
                Fault  = r_fault;
                w_next = IDLE;
            end
        endcase
        if (!reset) Stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_access) begin
                r_fault <= w_illegal;
                r_cnt   <= '0;
                if (w_illegal) begin
                    r_rdata <= '0;
                end else begin
                    r_addr  <= {Addr[31:2], 2'b00};
                    r_we    <= MemWrite;
                    r_wdata <= w_wdata;
                    r_be    <= w_be;
                    r_f3    <= Funct3;
                    r_off   <= Addr[1:0];
                end
            end
            // an arriving exit condition wins over an expiring budget
            if (r_state == REQ || r_state == RSP) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_timeout && !w_exit) begin
                    r_fault <= 1'b1;
                    r_rdata <= '0;
                end else if (r_state == RSP && mem_rsp_valid && !r_we) begin
                    r_rdata <= w_load;
                end
            end
        end
    end
endmodule
